// File: rtl/slc3_mem_responder_if.sv
// SRAM-style strobe bus between the SLC-3 datapath and the memory responder.
interface slc3_mem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] ADDR;
  logic [15:0]       Data_in;
  logic [15:0]       Data_out;
  logic              Data_valid;
  logic              Busy;
  logic              Err;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    input  Data_out, Data_valid, Busy, Err
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    output Data_out, Data_valid, Busy, Err
  );
endinterface

// File: rtl/slc3_mem_responder.sv
// SRAM stand-in for the SLC-3: decodes active-low strobes, byte-lane writes,
// registered reads with configurable read/write latency.
module slc3_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input logic                 Clk,
  input logic                 Reset,
  slc3_mem_responder_if.slave bus
);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX - 1) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [1:0]        r_lanes;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [15:0]       r_dout;
  logic              r_valid, w_valid_nxt;
  logic              r_err, w_err_nxt;
  logic [15:0]       r_mem [0:DEPTH-1];

  logic              w_rd_req, w_wr_req, w_illegal, w_latch;
  logic [1:0]        w_lanes_in;
  logic              w_commit, w_load;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [15:0]       w_wr_data, w_rd_word, w_rd_mask;
  logic [1:0]        w_wr_lanes, w_rd_lanes;

  assign w_rd_req   = !bus.Mem_CE && !bus.Mem_OE &&  bus.Mem_WE;
  assign w_wr_req   = !bus.Mem_CE && !bus.Mem_WE &&  bus.Mem_OE;
  assign w_illegal  = !bus.Mem_CE && !bus.Mem_OE && !bus.Mem_WE;
  assign w_lanes_in = {~bus.Mem_UB, ~bus.Mem_LB};
  assign w_latch    = (r_state == IDLE) && (w_rd_req || w_wr_req);

  // Next-state, counter and access-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_err_nxt   = 1'b0;
    w_commit    = 1'b0;
    w_wr_addr   = r_addr;
    w_wr_data   = r_wdata;
    w_wr_lanes  = r_lanes;
    w_load      = 1'b0;
    w_rd_addr   = r_addr;
    w_rd_lanes  = r_lanes;
    unique case (r_state)
      IDLE: begin
        // Latency-1 accesses bypass the latch and use the live bus values
        if (w_rd_req) begin
          if (RD_LAT == 1) begin
            w_load      = 1'b1;
            w_rd_addr   = bus.ADDR;
            w_rd_lanes  = w_lanes_in;
            w_valid_nxt = 1'b1;
            w_state_nxt = RD_HOLD;
          end else begin
            w_cnt_nxt   = CNT_W'(RD_LAT - 2);
            w_state_nxt = RD_WAIT;
          end
        end else if (w_wr_req) begin
          if (WR_LAT == 1) begin
            w_commit    = 1'b1;
            w_wr_addr   = bus.ADDR;
            w_wr_data   = bus.Data_in;
            w_wr_lanes  = w_lanes_in;
            w_state_nxt = WR_HOLD;
          end else begin
            w_cnt_nxt   = CNT_W'(WR_LAT - 2);
            w_state_nxt = WR_WAIT;
          end
        end else if (w_illegal) begin
          w_err_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.Mem_CE) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = RD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (bus.Mem_CE || bus.Mem_OE) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        if (bus.Mem_CE) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (bus.Mem_CE || bus.Mem_WE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_rd_word = r_mem[w_rd_addr];
  assign w_rd_mask = {{8{w_rd_lanes[1]}}, {8{w_rd_lanes[0]}}};

  // Request latch, latency counter and registered read/error outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_lanes <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr  <= bus.ADDR;
        r_wdata <= bus.Data_in;
        r_lanes <= w_lanes_in;
      end
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (w_load) r_dout <= w_rd_word & w_rd_mask;
    end
  end

  // Byte-lane write port; storage is deliberately untouched by Reset
  always_ff @(posedge Clk) begin
    if (w_commit) begin
      if (w_wr_lanes[1]) r_mem[w_wr_addr][15:8] <= w_wr_data[15:8];
      if (w_wr_lanes[0]) r_mem[w_wr_addr][7:0]  <= w_wr_data[7:0];
    end
  end

  assign bus.Data_out   = r_dout;
  assign bus.Data_valid = r_valid;
  assign bus.Busy       = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign bus.Err        = r_err;
endmodule
